// File: rtl/thread_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : thread_sched_pkg
// Brief    : Shared constants and types for the 8-thread issue scheduler.
// Revision : 1.0
// ============================================================================
package thread_sched_pkg;

   localparam int          NUM_TRD  = 8;
   localparam int          TRD_W    = 3;
   localparam int          PC_W     = 32;
   localparam logic [31:0] START_PC = 32'h0000_1000;

   typedef enum logic [1:0] {
      PARK  = 2'd0,
      READY = 2'd1,
      WAIT  = 2'd2
   } trd_state_t;

endpackage
`default_nettype wire

// File: rtl/thread_sched_rr_arb8.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb8
// Brief    : Combinational 8-way round-robin arbiter, priority from last+1.
// Revision : 1.0
// ============================================================================
module rr_arb8
   import thread_sched_pkg::*;
(
   input  logic [NUM_TRD-1:0] i_req,
   input  logic [TRD_W-1:0]   i_last_trd,
   output logic [NUM_TRD-1:0] o_gnt,
   output logic [TRD_W-1:0]   o_gnt_id
);

   logic [TRD_W-1:0] w_idx;
   logic             w_found;

   always_comb begin
      o_gnt    = '0;
      o_gnt_id = '0;
      w_found  = 1'b0;
      w_idx    = '0;
      // 3-bit addition wraps 7->0 on its own
      for (int k = 1; k <= NUM_TRD; k++) begin
         w_idx = i_last_trd + TRD_W'(k);
         if (!w_found && i_req[w_idx]) begin
            w_found      = 1'b1;
            o_gnt[w_idx] = 1'b1;
            o_gnt_id     = w_idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/thread_sched.sv
`default_nettype none
// ============================================================================
// Module   : thread_sched
// Brief    : Per-thread PC/state tracking with round-robin single-cycle issue.
// Revision : 1.0
// ============================================================================
module thread_sched
   import thread_sched_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PC_W-1:0]  nxt_pc_0,
   input  logic [PC_W-1:0]  nxt_pc_1,
   input  logic [PC_W-1:0]  nxt_pc_2,
   input  logic [PC_W-1:0]  nxt_pc_3,
   input  logic [PC_W-1:0]  nxt_pc_4,
   input  logic [PC_W-1:0]  nxt_pc_5,
   input  logic [PC_W-1:0]  nxt_pc_6,
   input  logic [PC_W-1:0]  nxt_pc_7,
   input  logic [7:0]       pc_wr,
   input  logic [7:0]       trd_en,
   input  logic             i_miss,
   input  logic [2:0]       i_miss_trd,
   input  logic             d_miss,
   input  logic [2:0]       d_miss_trd,
   input  logic             fill_vld,
   input  logic [2:0]       fill_trd,
   input  logic             stall,
   output logic             issue_vld,
   output logic [2:0]       cur_trd,
   output logic [PC_W-1:0]  cur_pc,
   output logic [15:0]      trd_state
);

   logic [PC_W-1:0]    w_nxt_pc [NUM_TRD];
   logic [PC_W-1:0]    w_pc     [NUM_TRD];
   logic [NUM_TRD-1:0] w_miss;
   logic [NUM_TRD-1:0] w_fill;
   logic [NUM_TRD-1:0] w_elig;
   logic [NUM_TRD-1:0] w_gnt;
   logic [TRD_W-1:0]   w_gnt_id;
   logic [PC_W-1:0]    w_sel_pc;

   logic               r_issue_vld;
   logic [TRD_W-1:0]   r_cur_trd;
   logic [PC_W-1:0]    r_cur_pc;
   logic [TRD_W-1:0]   r_last_trd;

   assign w_nxt_pc[0] = nxt_pc_0;
   assign w_nxt_pc[1] = nxt_pc_1;
   assign w_nxt_pc[2] = nxt_pc_2;
   assign w_nxt_pc[3] = nxt_pc_3;
   assign w_nxt_pc[4] = nxt_pc_4;
   assign w_nxt_pc[5] = nxt_pc_5;
   assign w_nxt_pc[6] = nxt_pc_6;
   assign w_nxt_pc[7] = nxt_pc_7;

   generate
      for (genvar i = 0; i < NUM_TRD; i++) begin : g_trd
         logic [PC_W-1:0] r_pc;
         trd_state_t      r_state;
         trd_state_t      w_state_nxt;

         assign w_miss[i] = (i_miss && (i_miss_trd == TRD_W'(i))) ||
                            (d_miss && (d_miss_trd == TRD_W'(i)));
         assign w_fill[i] = fill_vld && (fill_trd == TRD_W'(i));
         // A same-cycle miss masks the thread before it reaches WAIT
         assign w_elig[i] = (r_state == READY) && !w_miss[i];

         assign w_pc[i]           = r_pc;
         assign trd_state[2*i+:2] = r_state;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               r_pc <= START_PC;
            else if (pc_wr[i])
               r_pc <= w_nxt_pc[i];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               r_state <= PARK;
            else
               r_state <= w_state_nxt;
         end

         always_comb begin
            w_state_nxt = r_state;
            if (!trd_en[i]) begin
               w_state_nxt = PARK;
            end else begin
               case (r_state)
                  PARK:    w_state_nxt = READY;
                  READY:   if (w_miss[i]) w_state_nxt = WAIT;
                  // Miss beats a coincident fill: the thread stays waiting
                  WAIT:    if (w_fill[i] && !w_miss[i]) w_state_nxt = READY;
                  default: w_state_nxt = PARK;
               endcase
            end
         end
      end
   endgenerate

   rr_arb8 u_arb (
      .i_req      (w_elig),
      .i_last_trd (r_last_trd),
      .o_gnt      (w_gnt),
      .o_gnt_id   (w_gnt_id)
   );

   // One-hot PC mux with write-through of a same-cycle PC update
   always_comb begin
      w_sel_pc = '0;
      for (int k = 0; k < NUM_TRD; k++) begin
         if (w_gnt[k])
            w_sel_pc = w_sel_pc | (pc_wr[k] ? w_nxt_pc[k] : w_pc[k]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_issue_vld <= 1'b0;
         r_cur_trd   <= '0;
         r_cur_pc    <= START_PC;
         r_last_trd  <= TRD_W'(NUM_TRD - 1);
      end else if (!stall) begin
         if (|w_elig) begin
            r_issue_vld <= 1'b1;
            r_cur_trd   <= w_gnt_id;
            r_cur_pc    <= w_sel_pc;
            r_last_trd  <= w_gnt_id;
         end else begin
            r_issue_vld <= 1'b0;
         end
      end
   end

   assign issue_vld = r_issue_vld;
   assign cur_trd   = r_cur_trd;
   assign cur_pc    = r_cur_pc;

endmodule
`default_nettype wire

// File: tb/tb_thread_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_thread_sched
// Brief    : Directed table-driven bench for the thread scheduler.
// Revision : 1.0
// ============================================================================
module tb_thread_sched;

   localparam logic [31:0] SPC = 32'h0000_1000;
   localparam int          NV  = 36;

   typedef struct {
      logic [7:0]  en;
      logic [7:0]  wr;
      logic [31:0] npc;
      logic        im;
      logic [2:0]  imt;
      logic        dm;
      logic [2:0]  dmt;
      logic        fv;
      logic [2:0]  ft;
      logic        st;
      logic        ev;
      logic [2:0]  et;
      logic [31:0] ep;
      logic [15:0] es;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] nxt_pc [8];
   logic [7:0]  pc_wr;
   logic [7:0]  trd_en;
   logic        i_miss;
   logic [2:0]  i_miss_trd;
   logic        d_miss;
   logic [2:0]  d_miss_trd;
   logic        fill_vld;
   logic [2:0]  fill_trd;
   logic        stall;
   logic        issue_vld;
   logic [2:0]  cur_trd;
   logic [31:0] cur_pc;
   logic [15:0] trd_state;

   int   n_chk;
   int   n_fail;
   vec_t vec [NV];

   thread_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .nxt_pc_0   (nxt_pc[0]),
      .nxt_pc_1   (nxt_pc[1]),
      .nxt_pc_2   (nxt_pc[2]),
      .nxt_pc_3   (nxt_pc[3]),
      .nxt_pc_4   (nxt_pc[4]),
      .nxt_pc_5   (nxt_pc[5]),
      .nxt_pc_6   (nxt_pc[6]),
      .nxt_pc_7   (nxt_pc[7]),
      .pc_wr      (pc_wr),
      .trd_en     (trd_en),
      .i_miss     (i_miss),
      .i_miss_trd (i_miss_trd),
      .d_miss     (d_miss),
      .d_miss_trd (d_miss_trd),
      .fill_vld   (fill_vld),
      .fill_trd   (fill_trd),
      .stall      (stall),
      .issue_vld  (issue_vld),
      .cur_trd    (cur_trd),
      .cur_pc     (cur_pc),
      .trd_state  (trd_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic [7:0] en, input logic [7:0] wr, input logic [31:0] npc,
      input logic im, input logic [2:0] imt, input logic dm, input logic [2:0] dmt,
      input logic fv, input logic [2:0] ft, input logic st,
      input logic ev, input logic [2:0] et, input logic [31:0] ep, input logic [15:0] es);
      vec_t v;
      v.en = en; v.wr = wr; v.npc = npc;
      v.im = im; v.imt = imt; v.dm = dm; v.dmt = dmt;
      v.fv = fv; v.ft = ft; v.st = st;
      v.ev = ev; v.et = et; v.ep = ep; v.es = es;
      return v;
   endfunction

   // nxt_pc_i is driven as npc + i so each thread sees a distinct value
   task automatic apply(input vec_t v);
      for (int i = 0; i < 8; i++) nxt_pc[i] = v.npc + 32'(i);
      pc_wr      = v.wr;
      trd_en     = v.en;
      i_miss     = v.im;
      i_miss_trd = v.imt;
      d_miss     = v.dm;
      d_miss_trd = v.dmt;
      fill_vld   = v.fv;
      fill_trd   = v.ft;
      stall      = v.st;
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h required %h", nm, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input logic ev, input logic [2:0] et,
                          input logic [31:0] ep, input logic [15:0] es);
      chk("issue_vld", idx, 32'(issue_vld), 32'(ev));
      chk("cur_trd",   idx, 32'(cur_trd),   32'(et));
      chk("cur_pc",    idx, cur_pc,         ep);
      chk("trd_state", idx, 32'(trd_state), 32'(es));
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;

      // Full rotation after reset
      vec[0] = mk(8'hFF, 8'h00, 0, 0,0, 0,0, 0,0, 0,  0, 3'd0, SPC, 16'h5555);
      for (int k = 1; k <= 9; k++)
         vec[k] = mk(8'hFF, 8'h00, 0, 0,0, 0,0, 0,0, 0, 1, 3'(k - 1), SPC, 16'h5555);
      // Stall with PC writes to threads 1 and 2, then resume at last+1
      vec[10] = mk(8'hFF, 8'h02, 32'h2000, 0,0, 0,0, 0,0, 1, 1, 3'd0, SPC,          16'h5555);
      vec[11] = mk(8'hFF, 8'h04, 32'h3000, 0,0, 0,0, 0,0, 1, 1, 3'd0, SPC,          16'h5555);
      vec[12] = mk(8'hFF, 8'h00, 0,        0,0, 0,0, 0,0, 1, 1, 3'd0, SPC,          16'h5555);
      vec[13] = mk(8'hFF, 8'h00, 0,        0,0, 0,0, 0,0, 0, 1, 3'd1, 32'h2001,     16'h5555);
      vec[14] = mk(8'hFF, 8'h00, 0,        0,0, 0,0, 0,0, 0, 1, 3'd2, 32'h3002,     16'h5555);
      // d_miss on thread 3 when it is next; fill brings it back
      vec[15] = mk(8'hFF, 8'h00, 0, 0,0, 1,3, 0,0, 0, 1, 3'd4, SPC,      16'h5595);
      vec[16] = mk(8'hFF, 8'h00, 0, 0,0, 0,0, 0,0, 0, 1, 3'd5, SPC,      16'h5595);
      vec[17] = mk(8'hFF, 8'h00, 0, 0,0, 0,0, 1,3, 0, 1, 3'd6, SPC,      16'h5555);
      vec[18] = mk(8'hFF, 8'h00, 0, 0,0, 0,0, 0,0, 0, 1, 3'd7, SPC,      16'h5555);
      vec[19] = mk(8'hFF, 8'h00, 0, 0,0, 0,0, 0,0, 0, 1, 3'd0, SPC,      16'h5555);
      vec[20] = mk(8'hFF, 8'h00, 0, 0,0, 0,0, 0,0, 0, 1, 3'd1, 32'h2001, 16'h5555);
      vec[21] = mk(8'hFF, 8'h00, 0, 0,0, 0,0, 0,0, 0, 1, 3'd2, 32'h3002, 16'h5555);
      vec[22] = mk(8'hFF, 8'h00, 0, 0,0, 0,0, 0,0, 0, 1, 3'd3, SPC,      16'h5555);
      // Only threads 0 and 2 enabled; bypass of nxt_pc_2 = 0x100
      vec[23] = mk(8'h05, 8'h00, 0,     0,0, 0,0, 0,0, 0, 1, 3'd4, SPC,       16'h0011);
      vec[24] = mk(8'h05, 8'h00, 0,     0,0, 0,0, 0,0, 0, 1, 3'd0, SPC,       16'h0011);
      vec[25] = mk(8'h05, 8'h04, 32'hFE,0,0, 0,0, 0,0, 0, 1, 3'd2, 32'h100,   16'h0011);
      vec[26] = mk(8'h05, 8'h00, 0,     0,0, 0,0, 0,0, 0, 1, 3'd0, SPC,       16'h0011);
      vec[27] = mk(8'h05, 8'h00, 0,     0,0, 0,0, 0,0, 0, 1, 3'd2, 32'h100,   16'h0011);
      // Single eligible thread issues back to back, then none eligible
      vec[28] = mk(8'h05, 8'h00, 0, 1,0, 0,0, 0,0, 0, 1, 3'd2, 32'h100, 16'h0012);
      vec[29] = mk(8'h05, 8'h00, 0, 0,0, 0,0, 0,0, 0, 1, 3'd2, 32'h100, 16'h0012);
      vec[30] = mk(8'h05, 8'h00, 0, 0,0, 1,2, 0,0, 0, 0, 3'd2, 32'h100, 16'h0022);
      // Thread 5: miss and fill together keeps it in WAIT
      vec[31] = mk(8'h25, 8'h00, 0, 0,0, 0,0, 0,0, 0, 0, 3'd2, 32'h100, 16'h0422);
      vec[32] = mk(8'h25, 8'h00, 0, 1,5, 0,0, 0,0, 0, 0, 3'd2, 32'h100, 16'h0822);
      vec[33] = mk(8'h25, 8'h00, 0, 1,5, 0,0, 1,5, 0, 0, 3'd2, 32'h100, 16'h0822);
      vec[34] = mk(8'h25, 8'h00, 0, 0,0, 0,0, 1,0, 0, 0, 3'd2, 32'h100, 16'h0821);
      vec[35] = mk(8'h25, 8'h00, 0, 0,0, 0,0, 0,0, 0, 1, 3'd0, SPC,     16'h0821);

      rst_n = 1'b0;
      apply(mk(8'h00, 8'h00, 0, 0,0, 0,0, 0,0, 0, 0, 3'd0, SPC, 16'h0000));
      @(posedge clk); #1;
      chk_all(-1, 1'b0, 3'd0, SPC, 16'h0000);

      rst_n = 1'b1;
      for (int k = 0; k < NV; k++) begin
         apply(vec[k]);
         @(posedge clk); #1;
         chk_all(k, vec[k].ev, vec[k].et, vec[k].ep, vec[k].es);
      end

      // Asynchronous reset mid-WAIT, visible before any clock edge
      #2;
      rst_n = 1'b0;
      apply(mk(8'h00, 8'h00, 0, 0,0, 0,0, 1,2, 0, 0, 3'd0, SPC, 16'h0000));
      #1;
      chk_all(100, 1'b0, 3'd0, SPC, 16'h0000);
      @(posedge clk); #1;
      rst_n = 1'b1;
      // Fill for a parked thread is ignored
      @(posedge clk); #1;
      chk_all(101, 1'b0, 3'd0, SPC, 16'h0000);
      apply(mk(8'h05, 8'h00, 0, 0,0, 0,0, 0,0, 0, 0, 3'd0, SPC, 16'h0000));
      @(posedge clk); #1;
      chk_all(102, 1'b0, 3'd0, SPC, 16'h0011);
      @(posedge clk); #1;
      chk_all(103, 1'b1, 3'd0, SPC, 16'h0011);
      // Thread 2 PC was 0x100 before reset; must be back at start
      @(posedge clk); #1;
      chk_all(104, 1'b1, 3'd2, SPC, 16'h0011);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
